// File: rtl/serial_arith_pkg.sv
// Package: serial_arith_pkg
// Purpose: shared types and constants for the bit-serial arithmetic block.
//   state_t          - FSM encoding (IDLE, RUN)
//   SERIAL_WIDTH_DEF - default operand width
package serial_arith_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SERIAL_WIDTH_DEF = 8;

endpackage : serial_arith_pkg

// File: rtl/serial_adder_full_add1.sv
// Module: full_add1
// Purpose: combinational one-bit full adder cell.
// Ports:
//   a, b, cin - input bits
//   s         - sum bit       (a ^ b ^ cin)
//   cout      - carry-out bit (majority of a, b, cin)
module full_add1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_add1

// File: rtl/serial_adder.sv
// Module: serial_adder
// Purpose: bit-serial ripple adder. Adds two WIDTH-bit operands plus a
//   carry-in, LSB first, one bit per clock through a single full_add1 cell
//   and a carry flop. start/busy/done handshake; sum/cout are held between
//   operations and only ever update on completion.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   start      - request, sampled only while idle
//   a, b, cin  - operands and carry-in, captured on an accepted start
//   busy       - high while an operation is in progress
//   done       - one-cycle pulse when sum/cout update
//   sum, cout  - result and carry-out, held until the next completion
// Configuration:
//   SERIAL_SUB_EN - when defined, adds input 'sub'. With sub=1 the block
//   computes a - b - cin (cin acts as borrow-in, cout as borrow-out).
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // Subtract mode select: the value presented at start, and the value
  // captured for the operation in flight.
  logic               sub_in_s;
  logic               sub_cur_s;

`ifdef SERIAL_SUB_EN
  logic               sub_q, sub_d;
  assign sub_in_s  = sub;
  assign sub_cur_s = sub_q;
`else
  assign sub_in_s  = 1'b0;
  assign sub_cur_s = 1'b0;
`endif

  // Subtraction is a + ~b + ~cin: invert b into the cell, invert the
  // initial carry, and invert the final carry to obtain the borrow.
  logic fa_b_s;
  logic fa_s_s;
  logic fa_cout_s;

  assign fa_b_s = b_q[0] ^ sub_cur_s;

  full_add1 u_fa (
    .a    (a_q[0]),
    .b    (fa_b_s),
    .cin  (carry_q),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  // Next-state, datapath shift and completion logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef SERIAL_SUB_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin ^ sub_in_s;
          cnt_d   = {CNT_W{1'b0}};
          psum_d  = {WIDTH{1'b0}};
`ifdef SERIAL_SUB_EN
          sub_d   = sub;
`endif
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end

      RUN: begin
        // Result bits enter at the MSB so bit 0 lands at position 0
        // after WIDTH shifts.
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        psum_d  = {fa_s_s, psum_q[WIDTH-1:1]};
        carry_d = fa_cout_s;
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_cout_s ^ sub_cur_s;
          done_d  = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      psum_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      carry_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SERIAL_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder

// File: doc/serial_adder.md
Name:
serial_adder

Overview:
- Bit-serial ripple adder: adds two WIDTH-bit operands plus a carry-in, LSB first, one bit per clock, using a single full-adder cell and a carry flip-flop.
- Additive counterpart of the team's combinational full-subtractor cell. Used where area matters more than latency (arithmetic datapaths, test harnesses).
- start/busy/done handshake; the result is held stable between operations.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2)
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only when not busy
- a      input   WIDTH  operand A; captured on accepted start
- b      input   WIDTH  operand B; captured on accepted start
- cin    input   1      carry-in (borrow-in in subtract mode); captured on accepted start
- busy   output  1      high while an operation is in progress
- done   output  1      one-cycle pulse when sum/cout are updated
- sum    output  WIDTH  result, held until the next completion
- cout   output  1      carry-out (borrow-out in subtract mode), held with sum

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Internal shift registers, counter and carry are cleared.
- FSM has two states, IDLE and RUN.
- IDLE:
  - busy = 0.
  - If start = 1 at a clock edge, the block captures a, b and cin into internal shift registers and carry FF, clears the counter and moves to RUN.
- RUN:
  - busy = 1. Each edge processes bit 0 of the shift registers:
    - s = a0 ^ b0 ^ c
    - c_next = majority(a0, b0, c)
  - s shifts into the MSB of the partial-sum register; the operand registers shift right; the counter increments.
  - On the edge where the counter equals WIDTH-1:
    - sum <= completed partial-sum word; cout <= c_next.
    - done <= 1 for one cycle; state returns to IDLE and busy drops on that same edge.
- Latency: start sampled at edge 0 → done, sum and cout are valid in the cycle after edge WIDTH, so WIDTH cycles of busy.
- start while busy: ignored; the operands on the bus have no effect.
- start in the same cycle that done is high: accepted, because the state is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- sum and cout change only on completion and never show partial values.
- Reset mid-operation: the operation is aborted, all outputs go to 0, and no done pulse follows.
- Arithmetic is modulo 2^WIDTH; the overflow bit goes to cout.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- When defined:
  - Adds port sub (input, 1), captured on accepted start.
  - With sub = 1 the block computes a - b - cin: the b bits are inverted into the cell, the initial carry is ~cin, and on completion cout <= ~c_next (borrow out).
  - With sub = 0 the block behaves as an adder.
  - Per-bit results match the team's full-subtractor truth table.
- When undefined: the sub port is absent and the block is an adder only.

Decomposition:
- Package serial_arith_pkg holds:
  - state typedef enum {IDLE, RUN}
  - default width constant SERIAL_WIDTH_DEF = 8
- Sub-module full_add1: combinational one-bit full adder (a, b, cin → s, cout), instantiated once.
- The FSM, shift registers, counter and carry FF live in serial_adder.

Test Plan:
- Basic add: a=8'h5A, b=8'h3C, cin=0, start pulse → busy for 8 cycles, done pulse, sum=8'h96, cout=0.
- Carry chain: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Start while busy: start with a=8'h01, b=8'h01; re-assert start on the 3rd busy cycle with a=8'h10 → sum=8'h02, single done pulse; sum holds until the next start.
- Back-to-back: start asserted during the done cycle with a=8'h20, b=8'h03 → accepted, second done exactly 9 cycles after the first, sum=8'h23.
- Reset mid-op: rst_n low during the 4th RUN cycle → busy, done, sum and cout are 0 immediately; no done pulse after release.
- SERIAL_SUB_EN only:
  - sub=1, a=8'h10, b=8'h01, cin=0 → sum=8'h0F, cout=0.
  - sub=1, a=8'h00, b=8'h01, cin=0 → sum=8'hFF, cout=1.
